// File: rtl/line_window_buffer_if.sv
// Stream interface for line_window_buffer: tagged pixel beats in, tagged
// 3x3 windows out. The master side is the pixel source and consumer; the
// slave side is the window buffer itself.
interface line_window_buffer_if #(
  parameter int TAG_WIDTH   = 2,
  parameter int PIXEL_WIDTH = 8
);

  logic [PIXEL_WIDTH+TAG_WIDTH-1:0] data_in;
  logic [9*PIXEL_WIDTH-1:0]         window_out;
  logic [TAG_WIDTH-1:0]             tag_out;

  modport master (
    output data_in,
    input  window_out,
    input  tag_out
  );

  modport slave (
    input  data_in,
    output window_out,
    output tag_out
  );

endinterface

// File: rtl/line_window_buffer.sv
// line_window_buffer: builds a sliding 3x3 pixel window from a raster
// stream using two line memories. One tagged beat per cycle, no
// backpressure, one cycle latency from newest pixel to window.
//
// Optional feature: define LINE_WINDOW_BUFFER_COUNT_EN to add a 32-bit
// saturating window_count output counting emitted windows.
module line_window_buffer #(
  parameter int TAG_WIDTH    = 2,
  parameter int PIXEL_WIDTH  = 8,
  parameter int MAX_WIDTH    = 640,
  parameter int INVALID_TAG  = 0,
  parameter int DATA_TAG0    = 1,
  parameter int DATA_TAG1    = 2,
  parameter int DATA_END_TAG = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  refresh,
  input  logic [9:0]            image_width,
`ifdef LINE_WINDOW_BUFFER_COUNT_EN
  output logic [31:0]           window_count,
`endif
  line_window_buffer_if.slave   bus
);

  localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  localparam logic [TAG_WIDTH-1:0] TAG_INV  = TAG_WIDTH'(INVALID_TAG);
  localparam logic [TAG_WIDTH-1:0] TAG_D0   = TAG_WIDTH'(DATA_TAG0);
  localparam logic [TAG_WIDTH-1:0] TAG_D1   = TAG_WIDTH'(DATA_TAG1);
  localparam logic [TAG_WIDTH-1:0] TAG_END  = TAG_WIDTH'(DATA_END_TAG);

  logic [TAG_WIDTH-1:0]     in_tag;
  logic [PIXEL_WIDTH-1:0]   in_pixel;
  logic                     pixel_beat;
  logic                     end_beat;

  logic [9:0]               col;
  logic [1:0]               row;
  logic                     in_range;
  logic                     last_col;
  logic                     emit;
  logic [ADDR_W-1:0]        mem_addr;

  logic [PIXEL_WIDTH-1:0]   line0 [MAX_WIDTH];
  logic [PIXEL_WIDTH-1:0]   line1 [MAX_WIDTH];
  logic [PIXEL_WIDTH-1:0]   line0_rd;
  logic [PIXEL_WIDTH-1:0]   line1_rd;

  logic [9*PIXEL_WIDTH-1:0] shift_window;
  logic [9*PIXEL_WIDTH-1:0] next_window;

  assign in_tag     = bus.data_in[PIXEL_WIDTH +: TAG_WIDTH];
  assign in_pixel   = bus.data_in[PIXEL_WIDTH-1:0];
  assign pixel_beat = (in_tag == TAG_D0) || (in_tag == TAG_D1);
  assign end_beat   = (in_tag == TAG_END);

  // Columns beyond the line memory depth still count toward the row but
  // never touch the memories or produce a window.
  assign in_range = (int'(col) < MAX_WIDTH);
  assign last_col = (in_tag == TAG_D1) || (col == (image_width - 10'd1));
  assign emit     = pixel_beat && in_range && (row == 2'd2) &&
                    (col >= 10'd2) && (image_width >= 10'd3);
  assign mem_addr = in_range ? ADDR_W'(col) : '0;

  assign line0_rd = line0[mem_addr];
  assign line1_rd = line1[mem_addr];

  // Candidate window: shift the stored window left by one column and append
  // the column {two rows up, one row up, new pixel} read before the write.
  always_comb begin
    next_window = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        next_window[(r*3+c)*PIXEL_WIDTH +: PIXEL_WIDTH] =
          shift_window[(r*3+c+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
    next_window[2*PIXEL_WIDTH +: PIXEL_WIDTH] = line1_rd;
    next_window[5*PIXEL_WIDTH +: PIXEL_WIDTH] = line0_rd;
    next_window[8*PIXEL_WIDTH +: PIXEL_WIDTH] = in_pixel;
  end

  // Line memories: the previous line moves down one slot as the new pixel
  // lands, so line1 always holds the row two above the incoming one.
  always_ff @(posedge clock) begin
    if (reset && !refresh && pixel_beat && in_range) begin
      line1[mem_addr] <= line0_rd;
      line0[mem_addr] <= in_pixel;
    end
  end

  // Working window register, advanced on every in-range pixel beat even
  // when no window is being emitted, so row starts refill it naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_window <= '0;
    end else if (!refresh && pixel_beat && in_range) begin
      shift_window <= next_window;
    end
  end

  // Raster position tracking and output qualification; refresh wins over
  // any beat, an end marker passes through and restarts the frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col            <= '0;
      row            <= '0;
      bus.tag_out    <= TAG_INV;
      bus.window_out <= '0;
    end else if (refresh) begin
      col         <= '0;
      row         <= '0;
      bus.tag_out <= TAG_INV;
    end else if (end_beat) begin
      col         <= '0;
      row         <= '0;
      bus.tag_out <= TAG_END;
    end else if (pixel_beat) begin
      if (last_col) begin
        col <= '0;
        row <= (row == 2'd2) ? 2'd2 : row + 2'd1;
      end else begin
        col <= col + 10'd1;
      end
      if (emit) begin
        bus.tag_out    <= last_col ? TAG_D1 : TAG_D0;
        bus.window_out <= next_window;
      end else begin
        bus.tag_out <= TAG_INV;
      end
    end else begin
      bus.tag_out <= TAG_INV;
    end
  end

`ifdef LINE_WINDOW_BUFFER_COUNT_EN
  // Count emitted windows, sticking at the top value rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      window_count <= '0;
    end else if (refresh) begin
      window_count <= '0;
    end else if (emit && (window_count != 32'hFFFF_FFFF)) begin
      window_count <= window_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 2, tag field width.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8, pixel field width.
REQ-003 SHALL have parameter MAX_WIDTH, default 640, depth of each line memory and the largest supported image_width.
REQ-004 SHALL have parameters INVALID_TAG=0, DATA_TAG0=1, DATA_TAG1=2 (last pixel of row) and DATA_END_TAG=3.
REQ-005 SHALL have port clock, input, 1 bit, the single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port refresh, input, 1 bit, synchronous frame restart, active-high.
REQ-008 SHALL have port image_width, input, 10 bits, pixels per row.
REQ-009 SHALL have port data_in, input, PIXEL_WIDTH+TAG_WIDTH bits, {tag, pixel} stream, tag in the upper bits, one beat per cycle, no backpressure.
REQ-010 SHALL have port window_out, output, 9*PIXEL_WIDTH bits, 3x3 window in row-major order, oldest row and leftmost column in the lowest bits.
REQ-011 SHALL have port tag_out, output, TAG_WIDTH bits, tag qualifying window_out.

Function
REQ-012 A beat SHALL be a pixel beat when its tag is DATA_TAG0 or DATA_TAG1; INVALID_TAG beats SHALL change no state.
REQ-013 On each pixel beat, line memory 1 at column col SHALL take the line memory 0 value and line memory 0 at col SHALL take the new pixel, both in the same cycle.
REQ-014 On each pixel beat, the 3x3 window register SHALL shift left one column and load {line1[col], line0[col], pixel} (pre-write values) as the new rightmost column.
REQ-015 col SHALL increment per pixel beat, and SHALL return to 0 after DATA_TAG1 or after col == image_width-1, whichever comes first.
REQ-016 On each col wrap, row SHALL increment, saturating at 2.
REQ-017 Latency SHALL be 1 cycle: the window whose newest pixel arrived at cycle N SHALL appear at cycle N+1.
REQ-018 tag_out SHALL be DATA_TAG1 if the input beat was DATA_TAG1 or col was image_width-1, else DATA_TAG0, but only when row==2 and col>=2 at input time; otherwise INVALID_TAG.
REQ-019 Output image SHALL therefore be (W-2)x(H-2); the window centre is pixel (r-1, c-1).
REQ-020 A DATA_END_TAG input SHALL produce DATA_END_TAG on tag_out 1 cycle later and SHALL clear col and row.
REQ-021 When image_width < 3, no window SHALL be emitted; END pass-through SHALL still occur.
REQ-022 When image_width > MAX_WIDTH, columns >= MAX_WIDTH SHALL neither write the line memories nor emit a window, and col SHALL still wrap at image_width-1.
REQ-023 refresh SHALL clear col and row and force tag_out to INVALID_TAG next cycle, with priority over a simultaneous data beat; line memory contents need not be cleared.
REQ-024 window_out SHALL hold its value while tag_out is INVALID_TAG.

Reset
REQ-025 While reset is low, col, row, window_out and tag_out SHALL be zero (tag_out = INVALID_TAG), asynchronously.
REQ-026 Reset mid-frame SHALL discard the frame; the first row after release SHALL be treated as row 0.

Configuration
REQ-027 With LINE_WINDOW_BUFFER_COUNT_EN defined, there SHALL be an extra output window_count, 32 bits, counting beats with tag_out DATA_TAG0/DATA_TAG1, cleared by reset and refresh, saturating at 0xFFFFFFFF.
REQ-028 Without LINE_WINDOW_BUFFER_COUNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 width=4, 4x4 ramp 0..15 with TAG1 on col 3, then END -> exactly 4 windows; first window = {0,1,2,4,5,6,8,9,10} with tag TAG0; second ends TAG1; then END.
REQ-030 Same frame with INVALID beats inserted randomly -> identical window sequence, each 1 cycle after its last pixel.
REQ-031 width=3, no TAG1 on input (all TAG0) -> col wraps at 2; 3x3 frame yields one window tagged DATA_TAG1.
REQ-032 refresh asserted mid-row 2 together with a pixel beat -> tag_out INVALID next cycle; the following 3-row frame emits windows only from its own row 2.
REQ-033 reset pulled low mid-frame -> tag_out=0 and window_out=0 immediately; after release, a fresh 4x4 frame reproduces REQ-029.
REQ-034 With LINE_WINDOW_BUFFER_COUNT_EN, the REQ-029 frame -> window_count=4; refresh -> 0.
